sub_8_serial: RTL and testbench



---
 rtl/sub_8_serial_pkg.sv | 27 ++
 rtl/sub_8_serial_if.sv | 37 +++
 rtl/sub_8_serial_full_subtractor.sv | 22 ++
 rtl/sub_8_serial.sv | 125 ++++++++++++
 tb/tb_sub_8_serial.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/sub_8_serial_pkg.sv
// -----------------------------------------------------------------------------
// sub_8_serial_pkg
// Shared definitions for the bit-serial subtractor:
//   - WIDTH_DEF : default operand/result width
//   - CNT_W_DEF : bit-counter width for the default operand width
//   - state_t   : controller state encoding
//   - cnt_width : bit-counter width for an arbitrary operand width
// No ports (package).
// -----------------------------------------------------------------------------
package sub_8_serial_pkg;

  localparam int WIDTH_DEF = 8;

  // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sub_8_serial_if.sv
// -----------------------------------------------------------------------------
// sub_8_serial_if
// Start/done handshake and operand/result bus of the serial subtractor.
//   start  : request pulse (master -> slave)
//   a, b   : minuend / subtrahend, WIDTH bits (master -> slave)
//   bin    : borrow-in (master -> slave)
//   busy   : operation in progress (slave -> master)
//   done   : one-cycle result-valid pulse (slave -> master)
//   diff   : registered difference, WIDTH bits (slave -> master)
//   bout   : registered borrow-out (slave -> master)
// -----------------------------------------------------------------------------
interface sub_8_serial_if
  import sub_8_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );

endinterface

// File: rtl/sub_8_serial_full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// One-bit combinational subtractor cell: x - y - bi.
//   x  : minuend bit
//   y  : subtrahend bit
//   bi : borrow-in
//   d  : difference bit
//   bo : borrow-out (x < y + bi)
// -----------------------------------------------------------------------------
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  // Borrow when y alone exceeds x, or when x == y and a borrow is pending.
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/sub_8_serial.sv
// -----------------------------------------------------------------------------
// sub_8_serial
// Bit-serial WIDTH-bit subtractor, diff = a - b - bin, one bit per clock,
// LSB first, behind a start/done handshake.
//   clk : clock, rising edge
//   rst : synchronous reset, active-high, priority over start
//   bus : sub_8_serial_if.slave (start, a, b, bin in; busy, done, diff, bout out)
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | one bit processed per edge; last bit loads diff/bout
// DONE  | done pulse for one cycle; start here chains the next operation
// -----------------------------------------------------------------------------
module sub_8_serial
  import sub_8_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  sub_8_serial_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic busy;
  logic done;
  logic bit_d;
  logic bit_bo;

  full_subtractor u_cell (
    .x  (a_sh_q[0]),
    .y  (b_sh_q[0]),
    .bi (br_q),
    .d  (bit_d),
    .bo (bit_bo)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        done = (state_q == ST_DONE);
        if (bus.start) begin
          state_d = ST_SHIFT;
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          br_d    = bus.bin;
          res_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        busy   = 1'b1;
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        // Result fills from the MSB side so bit 0 lands at the LSB after WIDTH shifts.
        res_d  = {bit_d, res_q[WIDTH-1:1]};
        br_d   = bit_bo;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          diff_d  = {bit_d, res_q[WIDTH-1:1]};
          bout_d  = bit_bo;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_sub_8_serial.sv
module tb_sub_8_serial;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sub_8_serial_if #(.WIDTH(W)) bus ();

  sub_8_serial #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] held_diff;
  logic         held_bout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer subtraction, wrapped modulo 2^W.
  function automatic void ref_sub(input int a, input int b, input int bin,
                                  output int diff, output int bout);
    int s;
    s    = a - b - bin;
    bout = (s < 0) ? 1 : 0;
    diff = (s + (1 << W)) % (1 << W);
  endfunction

  // Called at a negedge; accepting edge is the following posedge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    check("accept_idle", {31'd0, bus.busy}, 32'd0);
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.bin   = 1'($urandom);
  endtask

  // Returns at the negedge where done is high.
  task automatic finish_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                           input bit inject);
    int  e_diff, e_bout, lat, busy_cyc;
    bit  seen;
    ref_sub(int'(a), int'(b), int'(bin), e_diff, e_bout);
    lat = 0; busy_cyc = 0; seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      check("busy_done_excl", {31'd0, bus.busy & bus.done}, 32'd0);
      if (bus.done) begin
        seen = 1;
        lat  = k + 1;
        break;
      end
      if (bus.busy) busy_cyc++;
      check("hold_diff", {24'd0, bus.diff}, {24'd0, held_diff});
      check("hold_bout", {31'd0, bus.bout}, {31'd0, held_bout});
      if (inject && k == 2) begin
        bus.start = 1'b1;
        bus.a     = ~a;
        bus.b     = a;
        bus.bin   = ~bin;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check("done_timeout", {31'd0, seen}, 32'd1);
    check("latency", lat, W + 1);
    check("busy_cycles", busy_cyc, W);
    check("diff", {24'd0, bus.diff}, e_diff);
    check("bout", {31'd0, bus.bout}, e_bout);
    check("identity", (int'(bus.diff) + int'(b) + int'(bin)) % (1 << W), int'(a));
    held_diff = W'(e_diff);
    held_bout = e_bout[0];
  endtask

  task automatic idle_watch(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("idle_done", {31'd0, bus.done}, 32'd0);
      check("idle_busy", {31'd0, bus.busy}, 32'd0);
      check("idle_diff", {24'd0, bus.diff}, {24'd0, held_diff});
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    start_op(a, b, bin);
    finish_op(a, b, bin, 1'b0);
    idle_watch(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rbin;

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    held_diff = '0;
    held_bout = 1'b0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_diff", {24'd0, bus.diff}, 32'd0);
    check("rst_bout", {31'd0, bus.bout}, 32'd0);
    rst = 1'b0;

    // Basic and wrap-around cases.
    run_op(8'd5,   8'd3,   1'b0);
    run_op(8'd3,   8'd5,   1'b0);
    run_op(8'h00,  8'h00,  1'b1);
    run_op(8'hFF,  8'hFF,  1'b0);
    run_op(8'h80,  8'h01,  1'b1);
    run_op(8'h00,  8'h01,  1'b0);

    // start during SHIFT is ignored, no extra done.
    start_op(8'h5A, 8'h33, 1'b1);
    finish_op(8'h5A, 8'h33, 1'b1, 1'b1);
    idle_watch(10);

    // Back-to-back: start held in the DONE cycle.
    start_op(8'h10, 8'h20, 1'b0);
    finish_op(8'h10, 8'h20, 1'b0, 1'b0);
    start_op(8'hA5, 8'h5A, 1'b1);
    finish_op(8'hA5, 8'h5A, 1'b1, 1'b0);
    idle_watch(1);

    // Reset mid-SHIFT aborts.
    start_op(8'hC3, 8'h11, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_diff", {24'd0, bus.diff}, 32'd0);
    check("abort_bout", {31'd0, bus.bout}, 32'd0);
    held_diff = '0;
    held_bout = 1'b0;
    idle_watch(12);

    // Small sweep with bin toggling.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        run_op(W'(i), W'(j), 1'((i * 8 + j) & 1));
      end
    end

    // Random operands.
    for (int r = 0; r < 24; r++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      run_op(ra, rb, rbin);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
